// File: rtl/arinc_tx_scheduler.sv
// ARINC429 TX scheduler: pops the TX FiFo one word at a time, optionally inserts odd parity,
// hands the word to the serializer via valid/ready and then enforces the inter-word gap.
module arinc_tx_scheduler #(
  parameter int unsigned DIV_HI   = 240,
  parameter int unsigned DIV_LO   = 1920,
  parameter int unsigned GAP_BITS = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             speed_hi,
  input  logic             parity_en,
  input  logic [31:0]      fifo_dout,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  output logic [31:0]      tx_word,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic             tx_done,
  output logic             tx_speed_hi,
  output logic             busy,
  output logic [CNT_W-1:0] words_sent
);

  localparam int unsigned GAP_MAX = GAP_BITS * DIV_LO;
  localparam int unsigned GAP_W   = $clog2(GAP_MAX + 1);
  localparam logic [GAP_W-1:0] GAP_LD_HI = GAP_W'(GAP_BITS * DIV_HI - 1);
  localparam logic [GAP_W-1:0] GAP_LD_LO = GAP_W'(GAP_BITS * DIV_LO - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LATCH,
    S_OFFER,
    S_SEND,
    S_GAP
  } state_t;

  state_t             state_q, state_d;
  logic               rd_q, rd_d;
  logic [31:0]        word_q, word_d;
  logic               valid_q, valid_d;
  logic               spd_q, spd_d;
  logic               par_q, par_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   sent_q, sent_d;
  logic [GAP_W-1:0]   gap_q, gap_d;

  always_comb begin
    state_d = state_q;
    rd_d    = 1'b0;
    word_d  = word_q;
    valid_d = valid_q;
    spd_d   = spd_q;
    par_d   = par_q;
    sent_d  = sent_q;
    gap_d   = gap_q;
    unique case (state_q)
      S_IDLE: begin
        if (en && !fifo_empty) begin
          state_d = S_POP;
          rd_d    = 1'b1;
          spd_d   = speed_hi;
          par_d   = parity_en;
        end
      end
      S_POP: state_d = S_LATCH;
      S_LATCH: begin
        word_d  = par_q ? {~^fifo_dout[30:0], fifo_dout[30:0]} : fifo_dout;
        valid_d = 1'b1;
        state_d = S_OFFER;
      end
      S_OFFER: begin
        if (tx_ready) begin
          valid_d = 1'b0;
          state_d = S_SEND;
        end
      end
      // tx_done is only looked at here, so a done coinciding with the handshake is dropped
      S_SEND: begin
        if (tx_done) begin
          state_d = S_GAP;
          sent_d  = sent_q + 1'b1;
          gap_d   = spd_q ? GAP_LD_HI : GAP_LD_LO;
        end
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      rd_q    <= 1'b0;
      word_q  <= '0;
      valid_q <= 1'b0;
      spd_q   <= 1'b0;
      par_q   <= 1'b0;
      busy_q  <= 1'b0;
      sent_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      spd_q   <= spd_d;
      par_q   <= par_d;
      busy_q  <= busy_d;
      sent_q  <= sent_d;
      gap_q   <= gap_d;
    end
  end

  assign fifo_rd_en  = rd_q;
  assign tx_word     = word_q;
  assign tx_valid    = valid_q;
  assign tx_speed_hi = spd_q;
  assign busy        = busy_q;
  assign words_sent  = sent_q;

endmodule
